mem_sram_req_ctrl: RTL and testbench
====================================

# mem_sram_req_ctrl

Data-side memory request controller between the CPU MEM stage and the data port of the sram-like-to-AXI bridge. It takes one load/store at a time from MEM and drives the bridge's sram-like data channel: req/wr/strb/addr/wdata, held until `data_addr_ok`, then waits for `data_data_ok`. For loads it sign- or zero-extends the returned word, then hands the result to WB through a valid/ready handshake. Only one access is outstanding at a time, and MEM is stalled until the access retires.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Fixed at 32; the strobe logic assumes 4 byte lanes.
- `TAG_W`, default 5: width of the destination tag carried through to WB.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `ms_valid`  in  1  MEM presents an access.
- `ms_ready`  out  1  block accepts the access.
- `ms_op`  in  3  operation: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
- `ms_addr`  in  ADDR_W  byte address.
- `ms_wdata`  in  DATA_W  store data, right-aligned.
- `ms_tag`  in  TAG_W  destination tag.
- `ws_valid`  out  1  result available to WB.
- `ws_ready`  in  1  WB consumes the result.
- `ws_rdata`  out  DATA_W  extended load data. 0 for stores.
- `ws_tag`  out  TAG_W  tag of the retired access.
- `ws_exc`  out  1  misaligned-access exception (see Configuration).
- `data_req`, `data_wr`  out  1  sram-like request and write flag.
- `strb`  out  4  byte-lane strobe.
- `data_addr`  out  32  request address.
- `data_wdata`  out  32  lane-replicated store data.
- `data_rdata`  in  32  returned word.
- `data_addr_ok`, `data_data_ok`  in  1  bridge address and data acknowledges.

## Operation
- State machine: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - `ms_ready`=1.
  - On `ms_valid`, register op, addr, wdata and tag, then go to REQ.
  - A misaligned access with the macro enabled goes to RESP instead.
- **REQ**
  - `data_req`=1 and `data_wr`=op[2]&(op!=4), i.e. ops 5..7.
  - All request fields come from registers and stay stable until `data_addr_ok`.
  - On `data_addr_ok`, go to WAIT.
  - If `data_addr_ok` and `data_data_ok` are high in the same cycle, go straight to RESP.
- **WAIT**
  - On `data_data_ok`, capture the extended `data_rdata` (loads) or 0 (stores), then go to RESP.
- **RESP**
  - `ws_valid`=1.
  - On `ws_ready`, go to IDLE.
- Strobe generation:
  - Byte ops: `4'b0001<<addr[1:0]`.
  - Half ops: `addr[1]?4'b1100:4'b0011`.
  - Word ops: `4'b1111`.
  - The strobe is driven for loads too.
- Store data replication:
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: passed through.
- Load extension:
  - The byte or half is selected by `addr[1:0]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- A `data_data_ok` arriving in IDLE, REQ (without `data_addr_ok`) or RESP is ignored.
- Reset values:
  - `ms_ready`=0 while `resetn` is low, then 1 in IDLE.
  - All other outputs are 0.
- Reset mid-operation: everything clears immediately and any in-flight bridge response is dropped, because stray `data_data_ok` is ignored.

## Timing
- Acceptance cycle: `ms_valid`&`ms_ready`.
- `data_req` rises one cycle after acceptance.
- Best-case load/store retirement, bridge acks in consecutive cycles:
  - `ws_valid` 3 cycles after acceptance.
  - Next `ms_ready` one cycle after `ws_ready`.
- Misaligned path (macro enabled): `ws_valid` one cycle after acceptance, and no `data_req` is ever issued.
- No combinational path from `data_*_ok` or `ws_ready` to `data_req`.
- `ws_*` outputs are registered.

## Configuration
- `MEM_MISALIGN_EXC_EN` defined:
  - Misaligned accesses are detected at acceptance: half ops with `addr[0]`=1, word ops with `addr[1:0]`≠0.
  - No bus request is made.
  - In RESP, `ws_exc`=1 and `ws_rdata`=faulting address.
- `MEM_MISALIGN_EXC_EN` undefined:
  - `ws_exc` is tied to 0.
  - `data_addr` low bits are forced to 0: bit 0 for half ops, bits 1:0 for word ops.
  - The access proceeds normally.

## Structure
- Package `mem_req_pkg`:
  - op encodings and `is_store`/`is_half`/`is_word` helper constants.
  - state encoding typedef (IDLE/REQ/WAIT/RESP).
- Sub-module `load_extend`: combinational unit taking op, addr[1:0] and the raw word, producing the extended result. It is reused by the uncached-load path later.

## Test plan
- **LW, no stall.** LW addr 0x1000, bridge returns 0xDEADBEEF with acks in consecutive cycles → strb 1111, `data_wr`=0, `ws_rdata`=0xDEADBEEF, `ws_valid` 3 cycles after acceptance.
- **LB / LBU extension.** LB and LBU at addr 0x1003, rdata 0x80112233 → strb 1000; `ws_rdata` 0xFFFFFF80 for LB, 0x00000080 for LBU.
- **SH with backpressure.** SH addr 0x2002, wdata 0x0000ABCD, `data_addr_ok` withheld 5 cycles → `data_req` held 5 cycles with stable fields, strb 1100, `data_wdata`=0xABCDABCD, `ws_rdata`=0.
- **WB backpressure.** `ws_ready` held low 4 cycles after a load → `ws_valid`, `ws_rdata` and `ws_tag` stay stable; `ms_ready` stays 0 throughout.
- **Misaligned word.** LW addr 0x1002 → with the macro: no `data_req`, `ws_exc`=1, `ws_rdata`=0x1002. Without the macro: `data_addr`=0x1000.
- **Reset mid-access.** Assert `resetn`=0 in WAIT, release, then inject a stray `data_data_ok` → all outputs 0 during reset; stray ack ignored; state IDLE with `ms_ready`=1.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared definitions for the data-side memory request controller:
// load/store op encodings, access-size helpers and the FSM state type.
package mem_req_pkg;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Stores are ops 5..7; op 4 (LW) shares op[2] but is a load.
    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (op != OP_LW);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment and extension: picks the byte or half addressed by
// addr_lo out of the returned word and sign/zero extends it. Purely
// combinational so the uncached-load path can share it.
module load_extend
    import mem_req_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and apply the op's extension rule
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (op)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'd0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_sram_req_ctrl.sv
// Data-side request controller between the MEM stage and the sram-like
// data port of the AXI bridge. One access outstanding at a time; the
// request fields are held in registers until the bridge takes the address,
// and the (extended) result is handed to WB over a registered valid/ready.
// Optional feature macro: MEM_MISALIGN_EXC_EN (misaligned accesses raise
// ws_exc instead of being issued with forced-aligned addresses).
module mem_sram_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ms_valid,
    output logic              ms_ready,
    input  logic [2:0]        ms_op,
    input  logic [ADDR_W-1:0] ms_addr,
    input  logic [DATA_W-1:0] ms_wdata,
    input  logic [TAG_W-1:0]  ms_tag,
    output logic              ws_valid,
    input  logic              ws_ready,
    output logic [DATA_W-1:0] ws_rdata,
    output logic [TAG_W-1:0]  ws_tag,
    output logic              ws_exc,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        strb,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic [31:0]       data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              exc_q, exc_d;

    logic              accept;
    logic              misalign;
    logic              capture;
    logic [31:0]       ext_word;
    logic [ADDR_W-1:0] addr_al;
    logic [3:0]        strb_calc;
    logic [31:0]       wdata_rep;

    // ms_ready is forced low while reset is asserted, not just by state.
    assign ms_ready = resetn & (state_q == ST_IDLE);
    assign accept   = ms_valid & ms_ready;

`ifdef MEM_MISALIGN_EXC_EN
    assign misalign = (is_half(ms_op) & ms_addr[0]) |
                      (is_word(ms_op) & (ms_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Returned data is captured when the bridge's data ack lands in WAIT,
    // or together with the address ack in REQ.
    assign capture = ((state_q == ST_REQ) & data_addr_ok & data_data_ok) |
                     ((state_q == ST_WAIT) & data_data_ok);

    load_extend u_load_extend (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .word    (data_rdata),
        .result  (ext_word)
    );

    // State register plus captured access fields and WB result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tag_q   <= tag_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    // Next-state logic; stray data acks outside REQ/WAIT fall through to hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)       state_d = misalign ? ST_RESP : ST_REQ;
            ST_REQ:  if (data_addr_ok) state_d = data_data_ok ? ST_RESP : ST_WAIT;
            ST_WAIT: if (data_data_ok) state_d = ST_RESP;
            ST_RESP: if (ws_ready)     state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Access field capture at acceptance and result capture on data ack
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tag_d   = tag_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        if (accept) begin
            op_d    = ms_op;
            addr_d  = ms_addr;
            wdata_d = ms_wdata;
            tag_d   = ms_tag;
            exc_d   = misalign;
            // A faulting access reports its address as the result.
            rdata_d = misalign ? DATA_W'(ms_addr) : '0;
        end else if (capture) begin
            rdata_d = is_store(op_q) ? '0 : DATA_W'(ext_word);
        end
    end

    // Request address, strobe and lane-replicated store data from registers
    always_comb begin
        addr_al = addr_q;
`ifndef MEM_MISALIGN_EXC_EN
        if (is_word(op_q)) begin
            addr_al[1:0] = 2'b00;
        end else if (is_half(op_q)) begin
            addr_al[0] = 1'b0;
        end
`endif
        if (is_word(op_q)) begin
            strb_calc = 4'b1111;
            wdata_rep = wdata_q[31:0];
        end else if (is_half(op_q)) begin
            strb_calc = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_q[15:0]}};
        end else begin
            strb_calc = 4'b0001 << addr_q[1:0];
            wdata_rep = {4{wdata_q[7:0]}};
        end
    end

    // FSM outputs; bus fields are zero whenever no request is driven
    always_comb begin
        data_req   = (state_q == ST_REQ);
        data_wr    = data_req & is_store(op_q);
        strb       = data_req ? strb_calc : 4'b0000;
        data_addr  = data_req ? 32'(addr_al) : 32'd0;
        data_wdata = data_req ? wdata_rep : 32'd0;
        ws_valid   = (state_q == ST_RESP);
        ws_rdata   = rdata_q;
        ws_tag     = tag_q;
        ws_exc     = exc_q;
    end

endmodule

// File: tb/tb_mem_sram_req_ctrl.sv
// Self-checking bench for mem_sram_req_ctrl: a table of directed accesses,
// hand-written reset/misalign sequences and randomized accesses checked
// against an arithmetic reference model. Honours MEM_MISALIGN_EXC_EN.
module tb_mem_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_valid;
    logic        ms_ready;
    logic [2:0]  ms_op;
    logic [31:0] ms_addr;
    logic [31:0] ms_wdata;
    logic [4:0]  ms_tag;
    logic        ws_valid;
    logic        ws_ready;
    logic [31:0] ws_rdata;
    logic [4:0]  ws_tag;
    logic        ws_exc;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  strb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_sram_req_ctrl #(.ADDR_W(32), .DATA_W(32), .TAG_W(5)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ms_valid     (ms_valid),
        .ms_ready     (ms_ready),
        .ms_op        (ms_op),
        .ms_addr      (ms_addr),
        .ms_wdata     (ms_wdata),
        .ms_tag       (ms_tag),
        .ws_valid     (ws_valid),
        .ws_ready     (ws_ready),
        .ws_rdata     (ws_rdata),
        .ws_tag       (ws_tag),
        .ws_exc       (ws_exc),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .strb         (strb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aok;
        int          dok;
        int          wsr;
        logic [3:0]  e_strb;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_res;
        bit          chkw;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access size in bytes and the lanes it covers
    function automatic int m_size(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 1;
        if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2;
        return 4;
    endfunction

    function automatic int m_start(input logic [2:0] op, input logic [31:0] addr);
        int s = m_size(op);
        return (int'(addr % 4) / s) * s;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] op, input logic [31:0] addr);
        int s = m_size(op);
        return 4'(((1 << s) - 1) << m_start(op, addr));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int s = m_size(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] op, input logic [31:0] addr,
                                          input logic [31:0] rd);
        int s = m_size(op);
        logic [31:0] v, mask;
        if (op > 3'd4) return 32'd0;
        if (s == 4) return rd;
        v    = rd >> (8 * m_start(op, addr));
        mask = (32'd1 << (8 * s)) - 32'd1;
        v    = v & mask;
        if ((op == 3'd0 || op == 3'd2) && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_mis(input logic [2:0] op, input logic [31:0] addr);
        return (addr % m_size(op)) != 0;
    endfunction

    function automatic logic [31:0] m_addr(input logic [2:0] op, input logic [31:0] addr);
        return addr - (addr % m_size(op));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ms_ready"},   32'(ms_ready), 32'd0);
        chk({tag, "_data_req"},   32'(data_req), 32'd0);
        chk({tag, "_data_wr"},    32'(data_wr), 32'd0);
        chk({tag, "_strb"},       32'(strb), 32'd0);
        chk({tag, "_data_addr"},  data_addr, 32'd0);
        chk({tag, "_data_wdata"}, data_wdata, 32'd0);
        chk({tag, "_ws_valid"},   32'(ws_valid), 32'd0);
        chk({tag, "_ws_rdata"},   ws_rdata, 32'd0);
        chk({tag, "_ws_tag"},     32'(ws_tag), 32'd0);
        chk({tag, "_ws_exc"},     32'(ws_exc), 32'd0);
    endtask

    // One complete access; starts and ends at a falling edge with the DUT idle
    task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic [4:0] tag,
                       input int aok, input int dok, input int wsr, input bit stray,
                       input bit exp_exc, input logic [3:0] e_strb, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic [31:0] e_res, input bit chkw);
        chk("idle_ms_ready", 32'(ms_ready), 32'd1);
        chk("idle_data_req", 32'(data_req), 32'd0);
        ms_valid = 1'b1; ms_op = op; ms_addr = addr; ms_wdata = wdata; ms_tag = tag;
        data_data_ok = stray;
        @(negedge clk);
        ms_valid = 1'b0; ms_addr = $urandom; ms_wdata = $urandom; ms_op = 3'($urandom);
        if (exp_exc) begin
            chk("exc_no_req", 32'(data_req), 32'd0);
        end else begin
            for (int k = 0; k <= aok; k++) begin
                chk("req", 32'(data_req), 32'd1);
                chk("data_wr", 32'(data_wr), 32'(op > 3'd4));
                chk("strb", 32'(strb), 32'(e_strb));
                chk("data_addr", data_addr, e_addr);
                if (chkw) chk("data_wdata", data_wdata, e_wdata);
                chk("req_ws_valid", 32'(ws_valid), 32'd0);
                chk("req_ms_ready", 32'(ms_ready), 32'd0);
                data_addr_ok = (k == aok);
                data_data_ok = (k == aok) ? (dok == 0) : stray;
                data_rdata   = (k == aok && dok == 0) ? rdata : $urandom;
                @(negedge clk);
            end
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            for (int j = 1; j <= dok; j++) begin
                chk("wait_req", 32'(data_req), 32'd0);
                chk("wait_ws_valid", 32'(ws_valid), 32'd0);
                data_data_ok = (j == dok);
                data_rdata   = (j == dok) ? rdata : $urandom;
                @(negedge clk);
            end
            data_data_ok = 1'b0;
        end
        for (int w = 0; w <= wsr; w++) begin
            chk("ws_valid", 32'(ws_valid), 32'd1);
            chk("ws_rdata", ws_rdata, e_res);
            chk("ws_tag", 32'(ws_tag), 32'(tag));
            chk("ws_exc", 32'(ws_exc), 32'(exp_exc));
            chk("resp_ms_ready", 32'(ms_ready), 32'd0);
            chk("resp_data_req", 32'(data_req), 32'd0);
            ws_ready     = (w == wsr);
            data_data_ok = stray;
            data_rdata   = $urandom;
            @(negedge clk);
        end
        ws_ready     = 1'b0;
        data_data_ok = 1'b0;
        chk("retire_ws_valid", 32'(ws_valid), 32'd0);
        chk("retire_ms_ready", 32'(ms_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr, wd, rd, eres;
        bit          exc;

        resetn = 1'b0; ms_valid = 1'b0; ms_op = '0; ms_addr = '0; ms_wdata = '0; ms_tag = '0;
        ws_ready = 1'b0; data_rdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;

        vecs[0]  = '{3'd4, 32'h1000, 32'h0,        32'hDEADBEEF, 0, 1, 0, 4'b1111, 32'h1000, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[1]  = '{3'd0, 32'h1003, 32'h0,        32'h80112233, 0, 1, 0, 4'b1000, 32'h1003, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[2]  = '{3'd1, 32'h1003, 32'h0,        32'h80112233, 0, 1, 0, 4'b1000, 32'h1003, 32'h0,        32'h00000080, 1'b0};
        vecs[3]  = '{3'd6, 32'h2002, 32'h0000ABCD, 32'h12121212, 5, 1, 0, 4'b1100, 32'h2002, 32'hABCDABCD, 32'h0,        1'b1};
        vecs[4]  = '{3'd4, 32'h3000, 32'h0,        32'h12345678, 0, 1, 4, 4'b1111, 32'h3000, 32'h0,        32'h12345678, 1'b0};
        vecs[5]  = '{3'd2, 32'h1002, 32'h0,        32'h80112233, 0, 1, 0, 4'b1100, 32'h1002, 32'h0,        32'hFFFF8011, 1'b0};
        vecs[6]  = '{3'd3, 32'h1000, 32'h0,        32'h80112233, 1, 2, 0, 4'b0011, 32'h1000, 32'h0,        32'h00002233, 1'b0};
        vecs[7]  = '{3'd5, 32'h4001, 32'h000000A5, 32'h0,        0, 2, 1, 4'b0010, 32'h4001, 32'hA5A5A5A5, 32'h0,        1'b1};
        vecs[8]  = '{3'd7, 32'h4000, 32'hCAFEF00D, 32'h0,        2, 0, 0, 4'b1111, 32'h4000, 32'hCAFEF00D, 32'h0,        1'b1};
        vecs[9]  = '{3'd0, 32'h1001, 32'h0,        32'h80112233, 0, 1, 0, 4'b0010, 32'h1001, 32'h0,        32'h00000022, 1'b0};
        vecs[10] = '{3'd4, 32'h5000, 32'h0,        32'h0F0F0F0F, 0, 0, 0, 4'b1111, 32'h5000, 32'h0,        32'h0F0F0F0F, 1'b0};
        vecs[11] = '{3'd2, 32'h1000, 32'h0,        32'h00007FFF, 0, 1, 2, 4'b0011, 32'h1000, 32'h0,        32'h00007FFF, 1'b0};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        resetn = 1'b1;
        #1;
        chk("rst_release_ms_ready", 32'(ms_ready), 32'd1);
        @(negedge clk);

        // Best-case latency: ws_valid exactly three cycles after acceptance
        ms_valid = 1'b1; ms_op = 3'd4; ms_addr = 32'h1000; ms_tag = 5'd9;
        chk("lat_c0_req", 32'(data_req), 32'd0);
        @(negedge clk);
        ms_valid = 1'b0;
        chk("lat_c1_req", 32'(data_req), 32'd1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("lat_c2_ws_valid", 32'(ws_valid), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("lat_c3_ws_valid", 32'(ws_valid), 32'd1);
        chk("lat_c3_rdata", ws_rdata, 32'hDEADBEEF);
        ws_ready = 1'b1;
        @(negedge clk);
        ws_ready = 1'b0;
        chk("lat_next_ms_ready", 32'(ms_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 5'(i + 1),
                vecs[i].aok, vecs[i].dok, vecs[i].wsr, 1'b0, 1'b0,
                vecs[i].e_strb, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_res, vecs[i].chkw);
        end

        // Misaligned word
`ifdef MEM_MISALIGN_EXC_EN
        txn(3'd4, 32'h1002, 32'h0, 32'h55667788, 5'd20, 0, 1, 1, 1'b0, 1'b1,
            4'b0, 32'h0, 32'h0, 32'h1002, 1'b0);
`else
        txn(3'd4, 32'h1002, 32'h0, 32'h55667788, 5'd20, 0, 1, 1, 1'b0, 1'b0,
            4'b1111, 32'h1000, 32'h0, 32'h55667788, 1'b0);
`endif

        // Reset while waiting for the data ack, then a stray ack afterwards
        ms_valid = 1'b1; ms_op = 3'd4; ms_addr = 32'h6000; ms_tag = 5'd7;
        @(negedge clk);
        ms_valid = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("mid_wait_req", 32'(data_req), 32'd0);
        resetn = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("stray_ms_ready", 32'(ms_ready), 32'd1);
        chk("stray_ws_valid", 32'(ws_valid), 32'd0);
        chk("stray_data_req", 32'(data_req), 32'd0);
        chk("stray_ws_rdata", ws_rdata, 32'd0);
        @(negedge clk);
        chk("stray_ws_valid2", 32'(ws_valid), 32'd0);

        // Randomized accesses against the reference model
        for (int n = 0; n < 300; n++) begin
            op   = 3'($urandom_range(0, 7));
            addr = $urandom & 32'h0000_FFFF;
            wd   = $urandom;
            rd   = $urandom;
`ifdef MEM_MISALIGN_EXC_EN
            exc  = m_mis(op, addr);
`else
            exc  = 1'b0;
`endif
            eres = exc ? addr : m_ext(op, addr, rd);
            txn(op, addr, wd, rd, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom), exc, m_strb(op, addr), m_addr(op, addr),
                m_wdata(op, wd), eres, op > 3'd4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
